// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: WIDTH-bit add run one nibble per cycle through one shared 4-bit CLA.
// Build option ADDER_SUB_EN adds a sub port that turns the operation into a - b.

// four_bit_cla: 4-bit carry-lookahead adder slice
module four_bit_cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [3:0] p, g;
  logic [4:0] c;
  assign p = a ^ b;
  assign g = a & b;
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
  assign s    = p ^ c[3:0];
  assign cout = c[4];
endmodule

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] a_reg, b_reg, b_in, nib_mask, nib_val;
  logic             carry, c_in, accept, last, cla_c;
  logic [IW-1:0]    idx;
  logic [IW+1:0]    sh;
  logic [3:0]       cla_a, cla_b, cla_s;

`ifdef ADDER_SUB_EN
  assign b_in = sub ? ~b : b;
  assign c_in = sub ? 1'b1 : cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif

  assign accept = (state == IDLE) && start;
  assign last   = idx == LAST;
  assign sh     = {idx, 2'b00};
  // shift-based nibble selection keeps every select in range, even for WIDTH=4
  assign cla_a    = 4'(a_reg >> sh);
  assign cla_b    = 4'(b_reg >> sh);
  assign nib_mask = WIDTH'(4'hf) << sh;
  assign nib_val  = WIDTH'(cla_s) << sh;

  four_bit_cla u_cla (
    .a    (cla_a),
    .b    (cla_b),
    .cin  (carry),
    .s    (cla_s),
    .cout (cla_c)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state: IDLE waits for start, RUN walks the nibbles, DONE lasts one cycle
  always_comb begin
    state_nxt = state;
    if (state == IDLE)     state_nxt = start ? RUN : IDLE;
    else if (state == RUN) state_nxt = last ? DONE : RUN;
    else                   state_nxt = IDLE;
  end

  // handshake outputs decoded from state
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
  end

  // operand capture and per-nibble result/carry update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_reg <= a;
      b_reg <= b_in;
      carry <= c_in;
      idx   <= '0;
    end else if (state == RUN) begin
      sum   <= (sum & ~nib_mask) | nib_val;
      carry <= cla_c;
      idx   <= last ? idx : idx + 1'b1;
      if (last) cout <= cla_c;
    end
  end
endmodule
